count_load_sequencer: RTL and testbench
=======================================

// Module: count_load_sequencer
// PURPOSE
//  Control stage directly upstream of the parallel-load up/down counter. Drives its load, data,
//  enable and direction inputs, and watches its count and carry-out. A requester hands over a
//  start value and a direction through a valid/ready handshake. The block loads the counter,
//  runs it to terminal count, then signals done, or reloads and repeats in auto-reload mode.
//  It also keeps a saturating tally of terminal-count events.
// PARAMETERS
//  DATA_WIDTH  8  counter width; must match the driven counter
//  TC_WIDTH    4  width of the terminal-event tally
// PORTS
//  Clk           in   1           rising-edge clock
//  RST_N         in   1           asynchronous active-low reset
//  req_valid_i   in   1           request present
//  req_ready_o   out  1           block can accept a request (high in IDLE only)
//  req_value_i   in   DATA_WIDTH  start value to load
//  req_dir_i     in   1           1 = count up, 0 = count down
//  req_reload_i  in   1           1 = auto-reload at terminal count
//  abort_i       in   1           stop the current job
//  cnt_value_i   in   DATA_WIDTH  counter output value (monitor only)
//  cnt_cout_i    in   1           counter carry-out
//  cnt_data_o    out  DATA_WIDTH  to counter data_i
//  cnt_load_o    out  1           to counter load_i
//  cnt_en_o      out  1           to counter e_i
//  cnt_dir_o     out  1           to counter d_i
//  busy_o        out  1           state is LOAD, RUN or DONE
//  done_o        out  1           one-cycle pulse at job completion
//  tc_count_o    out  TC_WIDTH    terminal events since the last accepted request
// BEHAVIOUR
//  - Counter contract: cnt_cout_i=1 while en=1 and value is all-ones (up) or all-zeros (down).
//    Load has priority over enable.
//  - Reset (async, RST_N=0): state=IDLE, all registers 0.
//    Outputs: req_ready_o=1, all other outputs 0.
//  - All outputs to the counter are Moore-decoded from registered state; no combinational input->output path.
//  - IDLE: req_ready_o=1, cnt_en_o=0, cnt_load_o=0.
//    On req_valid_i=1: capture value, dir and reload; clear tc_count_o; next state LOAD.
//  - LOAD: lasts exactly 1 cycle. cnt_load_o=1, cnt_en_o=0, cnt_data_o=captured value. Next state RUN.
//  - RUN: cnt_en_o=1, cnt_dir_o=captured dir.
//    On cnt_cout_i=1: tc_count_o += 1, saturating at all-ones.
//    After that edge the counter has wrapped (0x00 up, 0xFF down for W=8).
//    Next state is LOAD if reload=1, else DONE.
//  - DONE: done_o=1 and cnt_en_o=0 for 1 cycle. Next state IDLE.
//  - Latency: request accepted at edge k -> LOAD in cycle k+1 -> RUN from cycle k+2.
//    RUN lasts 2^W - V cycles counting up, or V+1 cycles counting down (V = start value).
//    The cout cycle is the last RUN cycle; DONE follows it.
//  - cnt_dir_o and cnt_data_o hold the captured values until the next accept.
//  - abort_i=1 in LOAD or RUN: next state IDLE. No done_o, tc_count_o unchanged.
//    abort_i wins over a simultaneous cnt_cout_i, and the tally is not incremented.
//    abort_i is ignored in IDLE and DONE.
//  - req_valid_i while busy: not accepted (ready=0).
//    A held request is accepted in the first IDLE cycle after DONE or abort.
//  - cnt_value_i is monitor-only and never alters state.
//  - Reset asserted mid-job returns to IDLE immediately (async) and drops cnt_en_o and cnt_load_o.
// TESTING (DATA_WIDTH=8, TC_WIDTH=4, bench includes the real counter)
//  1. req up, value 8'hFC, reload=0
//     -> load 1 cycle, 4 RUN cycles, done_o 1 cycle, tc_count_o=1, counter=8'h00, ready back.
//  2. req down, value 8'h03, reload=1
//     -> cout every 4 RUN cycles + 1 LOAD cycle; tc_count_o reaches 15 and holds at 15 after 20 events.
//  3. abort_i during RUN of an up job from 8'h10 (same cycle as cout in a variant)
//     -> IDLE next cycle, no done_o, tally unchanged.
//  4. req_valid_i held high during a job
//     -> ready=0 throughout; accepted on the first IDLE cycle; new dir/value driven from the next LOAD.
//  5. up from 8'hFF -> cout in the first RUN cycle, done_o 2 cycles after LOAD.
//     down from 8'h00 -> same timing.
//  6. RST_N low mid-RUN -> all outputs at reset values asynchronously; ready=1 after release.

Source files
------------

// File: rtl/count_load_sequencer.sv
// Sequencer that drives a parallel-load up/down counter: loads a requested start value,
// runs it to terminal count, then signals done or reloads, and tallies terminal events.
module count_load_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int TC_WIDTH   = 4
) (
    input  logic                  Clk,
    input  logic                  RST_N,
    // Request handshake: a request transfers on a rising edge where req_valid_i and
    // req_ready_o are both 1; the requester holds value/dir/reload stable until then.
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [DATA_WIDTH-1:0] req_value_i,
    input  logic                  req_dir_i,
    input  logic                  req_reload_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] cnt_value_i,
    input  logic                  cnt_cout_i,
    output logic [DATA_WIDTH-1:0] cnt_data_o,
    output logic                  cnt_load_o,
    output logic                  cnt_en_o,
    output logic                  cnt_dir_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [TC_WIDTH-1:0]   tc_count_o,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    logic   reload_q;

    // The counter value is observed for debug only and never steers the sequencer.
    logic unused_monitor;
    assign unused_monitor = ^cnt_value_i;

    assign dbg_state = state;

    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            reload_q    <= 1'b0;
            req_ready_o <= 1'b1;
            cnt_data_o  <= '0;
            cnt_load_o  <= 1'b0;
            cnt_en_o    <= 1'b0;
            cnt_dir_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            tc_count_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        state       <= LOAD;
                        cnt_data_o  <= req_value_i;
                        cnt_dir_o   <= req_dir_i;
                        reload_q    <= req_reload_i;
                        tc_count_o  <= '0;
                        req_ready_o <= 1'b0;
                        cnt_load_o  <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                LOAD: begin
                    cnt_load_o <= 1'b0;
                    if (abort_i) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                    end else begin
                        state    <= RUN;
                        cnt_en_o <= 1'b1;
                    end
                end
                RUN: begin
                    // Abort takes precedence over a same-cycle terminal count.
                    if (abort_i) begin
                        state       <= IDLE;
                        cnt_en_o    <= 1'b0;
                        busy_o      <= 1'b0;
                        req_ready_o <= 1'b1;
                    end else if (cnt_cout_i) begin
                        cnt_en_o <= 1'b0;
                        if (tc_count_o != {TC_WIDTH{1'b1}}) begin
                            tc_count_o <= tc_count_o + TC_WIDTH'(1);
                        end
                        if (reload_q) begin
                            state      <= LOAD;
                            cnt_load_o <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    done_o      <= 1'b0;
                    busy_o      <= 1'b0;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_load_sequencer.sv
// Bench for count_load_sequencer driving a behavioural up/down counter: table-driven jobs,
// hand-written corner sequences and randomized jobs scored against a trace model.
module tb_count_load_sequencer;

    logic       Clk;
    logic       RST_N;
    logic       req_valid_i;
    logic       req_ready_o;
    logic [7:0] req_value_i;
    logic       req_dir_i;
    logic       req_reload_i;
    logic       abort_i;
    logic [7:0] cnt_value;
    logic       cnt_cout;
    logic [7:0] cnt_data_o;
    logic       cnt_load_o;
    logic       cnt_en_o;
    logic       cnt_dir_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] tc_count_o;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    count_load_sequencer #(.DATA_WIDTH(8), .TC_WIDTH(4)) dut (
        .Clk(Clk), .RST_N(RST_N),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_value_i(req_value_i), .req_dir_i(req_dir_i), .req_reload_i(req_reload_i),
        .abort_i(abort_i),
        .cnt_value_i(cnt_value), .cnt_cout_i(cnt_cout),
        .cnt_data_o(cnt_data_o), .cnt_load_o(cnt_load_o), .cnt_en_o(cnt_en_o),
        .cnt_dir_o(cnt_dir_o), .busy_o(busy_o), .done_o(done_o),
        .tc_count_o(tc_count_o), .dbg_state(dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // behavioural parallel-load up/down counter
    always_ff @(posedge Clk or negedge RST_N) begin
        if (!RST_N)          cnt_value <= 8'h00;
        else if (cnt_load_o) cnt_value <= cnt_data_o;
        else if (cnt_en_o)   cnt_value <= cnt_dir_o ? cnt_value + 8'h01 : cnt_value - 8'h01;
    end
    assign cnt_cout = cnt_en_o && (cnt_dir_o ? (cnt_value == 8'hFF) : (cnt_value == 8'h00));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {ready, load, en, done, busy, dir, tc[3:0], data[7:0]}
    function automatic logic [16:0] pack_out();
        return {req_ready_o, cnt_load_o, cnt_en_o, done_o, busy_o, cnt_dir_o, tc_count_o, cnt_data_o};
    endfunction

    function automatic logic [16:0] mk(input logic rdy, input logic ld, input logic en,
                                       input logic dn, input logic bsy, input logic dr,
                                       input logic [3:0] tc, input logic [7:0] dt);
        return {rdy, ld, en, dn, bsy, dr, tc, dt};
    endfunction

    // scoreboard: per-cycle drive and expected-output queues
    typedef struct {
        logic       valid;
        logic       abort;
        logic       dir;
        logic       reload;
        logic [7:0] value;
    } drv_t;
    drv_t        drv_q[$];
    logic [16:0] exp_q[$];

    logic       m_dir;
    logic [7:0] m_data;
    logic [3:0] m_tc;

    task automatic push(input logic valid, input logic abort, input logic [7:0] value,
                        input logic dir, input logic [16:0] exp);
        drv_t d;
        d.valid  = valid;
        d.abort  = abort;
        d.value  = value;
        d.dir    = dir;
        d.reload = 1'b0;
        drv_q.push_back(d);
        exp_q.push_back(exp);
    endtask

    task automatic plan_idle();
        push(1'b0, 1'b0, 8'h00, 1'b0, mk(1, 0, 0, 0, 0, m_dir, m_tc, m_data));
    endtask

    // One job from the IDLE accept cycle to DONE (or to the aborted cycle).
    // abort_at: 1 = LOAD cycle, 2.. = RUN cycles, -1 = none. noise pulses abort in IDLE/DONE.
    task automatic plan_job(input logic [7:0] v, input logic d, input int abort_at,
                            input logic noise, input logic hold, input logic [7:0] hv,
                            input logic hd);
        int len;
        len = d ? 256 - int'(v) : int'(v) + 1;
        push(1'b1, noise, v, d, mk(1, 0, 0, 0, 0, m_dir, m_tc, m_data));
        m_dir  = d;
        m_data = v;
        m_tc   = 4'd0;
        push(hold, abort_at == 1, hv, hd, mk(0, 1, 0, 0, 1, d, 4'd0, v));
        if (abort_at == 1) return;
        for (int i = 0; i < len; i++) begin
            push(hold, abort_at == i + 2, hv, hd, mk(0, 0, 1, 0, 1, d, 4'd0, v));
            if (abort_at == i + 2) return;
        end
        m_tc = 4'd1;
        push(hold, noise, hv, hd, mk(0, 0, 0, 1, 1, d, 4'd1, v));
    endtask

    task automatic run_queue(input string tag);
        int   n;
        drv_t d;
        logic [16:0] e;
        n = 0;
        while (drv_q.size() > 0) begin
            @(negedge Clk);
            d = drv_q.pop_front();
            e = exp_q.pop_front();
            check($sformatf("%s_trace_%0d", tag, n), pack_out(), e);
            req_valid_i  = d.valid;
            abort_i      = d.abort;
            req_value_i  = d.value;
            req_dir_i    = d.dir;
            req_reload_i = d.reload;
            n++;
        end
    endtask

    // Table job: accept, then measure RUN length and LOAD-to-DONE distance.
    task automatic run_job(input logic [7:0] v, input logic d, output int run_len,
                           output int load_to_done);
        int cyc;
        @(negedge Clk);
        check("job_idle_ready", req_ready_o, 1'b1);
        req_valid_i = 1'b1; req_value_i = v; req_dir_i = d; req_reload_i = 1'b0;
        @(negedge Clk);
        req_valid_i = 1'b0;
        check("job_load", {cnt_load_o, cnt_en_o, cnt_data_o, cnt_dir_o}, {1'b1, 1'b0, v, d});
        cyc = 0;
        run_len = 0;
        while (cyc < 400) begin
            @(negedge Clk);
            cyc++;
            if (cnt_en_o) run_len++;
            if (done_o) break;
        end
        if (!done_o) check("job_done_timeout", 0, 1);
        load_to_done = cyc;
    endtask

    typedef struct {
        logic [7:0] v;
        logic       d;
        int         run_len;
        logic [7:0] final_cnt;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int   rl, ltd, events, last, cyc;

        tbl[0] = '{8'hFC, 1'b1, 4,  8'h00};
        tbl[1] = '{8'h03, 1'b0, 4,  8'hFF};
        tbl[2] = '{8'hFF, 1'b1, 1,  8'h00};
        tbl[3] = '{8'h00, 1'b0, 1,  8'hFF};
        tbl[4] = '{8'hF0, 1'b1, 16, 8'h00};
        tbl[5] = '{8'h0A, 1'b0, 11, 8'hFF};

        RST_N = 1'b0;
        req_valid_i = 1'b0; req_value_i = 8'h00; req_dir_i = 1'b0;
        req_reload_i = 1'b0; abort_i = 1'b0;
        repeat (2) @(negedge Clk);
        check("reset_outputs", {pack_out(), dbg_state}, {mk(1, 0, 0, 0, 0, 0, 4'd0, 8'h00), 2'd0});
        RST_N = 1'b1;

        // table-driven single jobs
        for (int i = 0; i < 6; i++) begin
            run_job(tbl[i].v, tbl[i].d, rl, ltd);
            check($sformatf("tbl%0d_run_len", i), rl, tbl[i].run_len);
            check($sformatf("tbl%0d_load_to_done", i), ltd, tbl[i].run_len + 1);
            check($sformatf("tbl%0d_tc", i), tc_count_o, 4'd1);
            check($sformatf("tbl%0d_counter", i), cnt_value, tbl[i].final_cnt);
            @(negedge Clk);
            check($sformatf("tbl%0d_ready_back", i), {req_ready_o, busy_o, done_o}, 3'b100);
        end

        // auto-reload down from 3: cout every 5 cycles, tally saturates at 15
        @(negedge Clk);
        req_valid_i = 1'b1; req_value_i = 8'h03; req_dir_i = 1'b0; req_reload_i = 1'b1;
        @(negedge Clk);
        req_valid_i = 1'b0; req_reload_i = 1'b0;
        events = 0; last = 0; cyc = 0;
        while (events < 20 && cyc < 300) begin
            @(negedge Clk);
            cyc++;
            check($sformatf("sat_tc_%0d", cyc), tc_count_o, (events > 15) ? 15 : events);
            if (cnt_cout) begin
                events++;
                if (events > 1) check($sformatf("sat_spacing_%0d", events), cyc - last, 5);
                last = cyc;
            end
        end
        check("sat_events", events, 20);
        @(negedge Clk);
        check("sat_final", {tc_count_o, cnt_load_o}, {4'd15, 1'b1});
        abort_i = 1'b1;
        @(negedge Clk);
        abort_i = 1'b0;
        check("sat_abort_idle", {req_ready_o, busy_o, done_o, tc_count_o}, {3'b100, 4'd15});
        m_dir = 1'b0; m_data = 8'h03; m_tc = 4'd15;

        // aborts: mid-RUN, on the cout cycle, in LOAD; abort noise in IDLE/DONE
        plan_job(8'h10, 1'b1, 6, 1'b0, 1'b0, 8'h00, 1'b0);
        plan_idle();
        plan_job(8'hFE, 1'b1, 3, 1'b0, 1'b0, 8'h00, 1'b0);
        plan_idle();
        plan_job(8'h02, 1'b0, 1, 1'b0, 1'b0, 8'h00, 1'b0);
        plan_job(8'h01, 1'b0, -1, 1'b1, 1'b0, 8'h00, 1'b0);
        plan_idle();
        // held request during a job, accepted on the first IDLE cycle
        plan_job(8'hFC, 1'b1, -1, 1'b0, 1'b1, 8'h05, 1'b0);
        plan_job(8'h05, 1'b0, -1, 1'b0, 1'b0, 8'h00, 1'b0);
        plan_idle();
        run_queue("seq");

        // randomized jobs
        for (int j = 0; j < 30; j++) begin
            logic       d;
            logic [7:0] v;
            int         len, ab;
            d   = 1'($urandom_range(0, 1));
            v   = d ? 8'(255 - $urandom_range(0, 15)) : 8'($urandom_range(0, 15));
            len = d ? 256 - int'(v) : int'(v) + 1;
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len + 1)) : -1;
            plan_job(v, d, ab, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
            if ($urandom_range(0, 1) == 1) plan_idle();
        end
        plan_idle();
        run_queue("rnd");

        // asynchronous reset in the middle of RUN
        @(negedge Clk);
        req_valid_i = 1'b1; req_value_i = 8'h10; req_dir_i = 1'b1;
        @(negedge Clk);
        req_valid_i = 1'b0;
        repeat (5) @(negedge Clk);
        check("pre_reset_run", {cnt_en_o, busy_o}, 2'b11);
        #2 RST_N = 1'b0;
        #1;
        check("async_reset_outputs", {pack_out(), dbg_state}, {mk(1, 0, 0, 0, 0, 0, 4'd0, 8'h00), 2'd0});
        @(negedge Clk);
        RST_N = 1'b1;
        @(negedge Clk);
        check("after_reset_ready", {req_ready_o, busy_o, cnt_en_o, cnt_load_o}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
